// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-transfer AHB-Lite master; one command in, one non-pipelined bus transfer, one response out.
module ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nx;
  logic        r_write;
  logic [31:0] r_addr, r_wdata;
  logic [2:0]  r_size;
  logic        hs, illegal;
  logic [31:0] lane;
  assign hs      = cmd_valid & cmd_ready;
  assign illegal = (cmd_size > 3'd2) | ((cmd_size == 3'd1) & cmd_addr[0]) | ((cmd_size == 3'd2) & (|cmd_addr[1:0]));
  assign lane    = (r_size == 3'd0) ? {24'b0, HRDATA[{r_addr[1:0], 3'b000} +: 8]} :
                   (r_size == 3'd1) ? {16'b0, HRDATA[{r_addr[1], 4'b0000} +: 16]} : HRDATA;
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = hs ? (illegal ? RESP : ADDR) : IDLE;
      ADDR: state_nx = HREADY ? DATA : ADDR;
      DATA: state_nx = HREADY ? RESP : DATA;
      RESP: state_nx = IDLE;
    endcase
  end
  // Illegal commands produce their error response at the handshake edge; legal ones at the final data cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (hs) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_size  <= cmd_size;
      end
      if (hs & illegal) begin
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
      end
      if ((state == DATA) & HREADY) begin
        rsp_error <= HRESP;
        rsp_rdata <= (HRESP | r_write) ? 32'h0 : lane;
      end
    end
  end
  assign cmd_ready = (state == IDLE) & ~HRESET;
  assign rsp_valid = (state == RESP);
  assign HTRANS    = (state == ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = (state == ADDR) ? r_addr : 32'h0;
  assign HWRITE    = (state == ADDR) & r_write;
  assign HSIZE     = (state == ADDR) ? r_size : 3'd0;
  assign HBURST    = 3'b000;
  assign HWDATA    = ((state == DATA) & r_write) ?
                     ((r_size == 3'd0) ? {4{r_wdata[7:0]}} : (r_size == 3'd1) ? {2{r_wdata[15:0]}} : r_wdata) : 32'h0;
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have port HCLK  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port HRESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port cmd_valid  in  1  a command is presented.
REQ-004 SHALL have port cmd_ready  out  1  the block accepts a command this cycle.
REQ-005 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-006 SHALL have port cmd_addr  in  32  byte address.
REQ-007 SHALL have port cmd_wdata  in  32  write data, right-justified.
REQ-008 SHALL have port cmd_size  in  3  AHB HSIZE encoding; 0=byte, 1=half, 2=word.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  out  32  read result, right-justified and zero-extended.
REQ-011 SHALL have port rsp_error  out  1  completion failed; valid with rsp_valid.
REQ-012 SHALL have ports HADDR out 32, HWDATA out 32, HWRITE out 1, HTRANS out 2, HSIZE out 3, HBURST out 3; these form the AHB-Lite master outputs.
REQ-013 SHALL have ports HRDATA in 32, HREADY in 1, HRESP in 1; these form the AHB-Lite master inputs.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA, RESP; reset state IDLE.
REQ-015 SHALL drive cmd_ready=1 only in IDLE; a handshake occurs when cmd_valid&cmd_ready are both 1.
REQ-016 SHALL register cmd_write, cmd_addr, cmd_wdata and cmd_size on handshake; command inputs are ignored elsewhere.
REQ-017 SHALL flag a command illegal if cmd_size>2, or if size=1 and addr[0]=1, or if size=2 and addr[1:0]!=0.
REQ-018 SHALL, for an illegal command, go IDLE->RESP with no bus activity (HTRANS stays IDLE), then assert rsp_valid=1, rsp_error=1, rsp_rdata=0.
REQ-019 SHALL, for a legal command, go IDLE->ADDR and drive HTRANS=NONSEQ(10), HADDR, HWRITE and HSIZE from registered values, with HBURST=SINGLE(000) always.
REQ-020 SHALL hold all address-phase outputs stable in ADDR until HREADY=1, then move to DATA.
REQ-021 SHALL drive HTRANS=IDLE(00) in every state except ADDR; transfers are never pipelined.
REQ-022 SHALL ignore HRESP in ADDR.
REQ-023 SHALL drive HWDATA in DATA (writes) with the byte lane replicated for size=0 ({4{b}}), the halfword replicated for size=1 ({2{h}}), and the full word for size=2; HWDATA SHALL be 0 outside DATA.
REQ-024 SHALL stay in DATA while HREADY=0.
REQ-025 SHALL, on the DATA cycle where HREADY=1, capture HRESP into rsp_error and capture the read lane, then go to RESP.
REQ-026 SHALL select the read lane little-endian: byte = HRDATA[8*addr[1:0]+:8], half = HRDATA[16*addr[1]+:16], zero-extended; rsp_rdata SHALL be 0 for writes and for errors.
REQ-027 SHALL complete a transfer with HRESP=1, HREADY=0 (first error cycle) by waiting in DATA; completion SHALL occur on the HRESP=1, HREADY=1 cycle with rsp_error=1.
REQ-028 SHALL assert rsp_valid=1 for exactly the one RESP cycle, then return to IDLE; rsp_rdata and rsp_error SHALL hold until the next RESP.
REQ-029 SHALL give zero-wait latency from handshake cycle N: ADDR at N+1, DATA at N+2, rsp_valid at N+3, cmd_ready at N+4.
REQ-030 SHALL extend that latency by one cycle per HREADY=0 cycle in ADDR or DATA.

Reset
REQ-031 SHALL, while HRESET=1, immediately force IDLE, HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
REQ-032 SHALL drive cmd_ready=1 in the first cycle after HRESET deasserts.
REQ-033 SHALL abandon an in-flight transfer on reset with no rsp_valid issued for it.

Verification
REQ-034 SHALL pass: word write addr 0x1000, data 0xDEADBEEF, HREADY=1 -> NONSEQ at N+1, HWDATA=0xDEADBEEF at N+2, rsp_valid at N+3 with rsp_error=0.
REQ-035 SHALL pass: byte read addr 0x2003, HRDATA=0xA1B2C3D4, two DATA wait states -> rsp_rdata=0x000000A1 at N+5.
REQ-036 SHALL pass: half write addr 0x10 size=1, data 0x1234 -> HWDATA=0x12341234.
REQ-037 SHALL pass: word read addr 0x0002 -> no NONSEQ ever issued, rsp_valid at N+1, rsp_error=1, rsp_rdata=0.
REQ-038 SHALL pass: read with a two-cycle ERROR response (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) -> a single rsp_valid with rsp_error=1 and rsp_rdata=0.
REQ-039 SHALL pass: HRESET asserted in DATA while HREADY=0 -> outputs reset asynchronously, no rsp_valid, cmd_ready=1 on the first cycle after release.
